uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares a single uart_tx serializer among N byte-stream requesters.
- Selects requesters round-robin and sequences the serializer's start/busy handshake, one byte per frame.
- Supports multi-byte message lock: a requester keeps the grant until it presents a byte flagged last.
- A lock timeout releases the grant if the owner stalls.
- Sits between the client blocks (command/response engines) and the uart_tx instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- LOCK_TIMEOUT, 65535, cycles a locked owner may idle between bytes before forced release.
- BUSY_WAIT_MAX, 7, cycles allowed for tx_busy to rise after tx_start before a handshake error.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  N_REQ  per-requester byte available
- req_data  in  8*N_REQ  per-requester byte; requester i uses bits [8i+7:8i]
- req_last  in  N_REQ  byte ends the requester's message (releases lock)
- req_ready  out  N_REQ  one-hot, single-cycle pulse: byte of that requester accepted
- tx_start  out  1  to uart_tx start; single-cycle pulse
- tx_data  out  8  to uart_tx data_in; held stable from the start pulse until busy falls
- tx_busy  in  1  from uart_tx busy
- grant_id  out  3  index of current owner; valid while grant_active
- grant_active  out  1  a requester owns the serializer (includes lock hold)
- lock_abort  out  1  single-cycle pulse on LOCK_TIMEOUT release
- hs_error  out  1  sticky; tx_busy failed to rise within BUSY_WAIT_MAX; cleared only by rst

Behaviour:
- Reset values:
  - req_ready=0, tx_start=0, tx_data=0, grant_id=0, grant_active=0, lock_abort=0, hs_error=0.
  - rr pointer=0; state=IDLE.
- All outputs are registered.

States:
- IDLE:
  - When tx_busy=0 and any req_valid is set, pick the first set bit scanning from rr_ptr upward with wrap; call it g.
  - In the same edge: req_ready[g]=1 (one cycle), tx_data<=req_data[g], tx_start<=1, grant_id<=g, grant_active<=1, lock<=~req_last[g].
  - Next state: WAIT_BUSY.
  - If tx_busy=1 in IDLE (external use), wait.
- WAIT_BUSY:
  - tx_start returns to 0 after one cycle.
  - Count cycles; on tx_busy=1, go to WAIT_DONE.
  - If the count reaches BUSY_WAIT_MAX, set hs_error=1, clear lock and grant_active, advance rr_ptr=g+1 mod N_REQ, go to IDLE.
- WAIT_DONE:
  - Wait for tx_busy=0.
  - If lock=1, go to HOLD with the timeout counter cleared.
  - Otherwise clear grant_active, set rr_ptr=g+1 mod N_REQ, go to IDLE.
- HOLD:
  - Only requester g is considered; other requesters are ignored.
  - If req_valid[g]=1: accept it exactly as in IDLE (same g), lock<=~req_last[g], go to WAIT_BUSY.
  - Otherwise increment the counter. At LOCK_TIMEOUT: lock_abort pulse, grant_active=0, rr_ptr=g+1, go to IDLE.

Timing and ordering:
- Latency: req_valid seen in IDLE to tx_start high is 1 cycle.
- Inter-frame gap: 2 cycles from busy falling to the next tx_start (WAIT_DONE→IDLE/HOLD, then accept).
- Only one req_ready per accepted byte; never two bits set at once.
- Requesters must hold req_valid/data until their ready pulse.
- Simultaneous requests are resolved strictly by rr_ptr order. No starvation: each requester waits at most N_REQ-1 messages.
- A req_valid deasserted before being granted is simply skipped.
- Async reset mid-frame returns to IDLE immediately; uart_tx shares rst, so no partial handshake survives.

Widths:
- The timeout counter is 16 bits (saturating compare, no wrap).
- The busy-wait counter is 3 bits.

Decomposition:
- Shared package (uart_pkg): state encoding IDLE/WAIT_BUSY/WAIT_DONE/HOLD and the default CLK_PER_BIT constant shared with uart_tx.
- One natural sub-module: rr_pick (combinational N_REQ-wide round-robin priority encoder).
  - Inputs: req mask and rr_ptr.
  - Outputs: index and found.

Test Plan (bench: N_REQ=4, uart_tx with CLK_PER_BIT=4, so a frame is 40 cycles):
- Single request: req_valid=0001, data 0xA5, last=1 → tx_start 1 cycle later; serial line shows 0,1,0,1,0,0,1,0,1,1 (start bit, LSB-first data, stop bit); grant_active drops after busy falls.
- All four valid simultaneously, last=1, data 0x10..0x13, rr_ptr=0 → frames in order 0x10,0x11,0x12,0x13; exactly four req_ready pulses, one-hot.
- Lock: req1 sends 3 bytes (last on third) while req0 and req2 are valid → req1's bytes are contiguous and uninterrupted, then req2 is served, then req0.
- Lock timeout with LOCK_TIMEOUT=20: req3 sends last=0 then drops valid → lock_abort pulses 20 cycles into HOLD; req0 is granted next.
- Stuck serializer: tx_busy forced to 0 → hs_error sets 7 cycles after tx_start, state returns to IDLE, pointer advances.
- Reset asserted mid-frame → all outputs return to reset values in the same cycle; the next request is granted from rr_ptr=0.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: arbiter state encoding and constants shared with uart_tx
package uart_pkg;
  localparam int CLK_PER_BIT = 434;
  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE, HOLD} arb_state_t;
  function automatic logic [2:0] next_idx(input logic [2:0] i, input int n);
    return (32'(i) == n - 1) ? 3'd0 : i + 3'd1;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: round-robin priority encoder, first set request at or above ptr with wrap
module rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [2:0]       ptr,
  output logic [2:0]       idx,
  output logic             found
);
  logic [N_REQ-1:0] rot;
  logic [2:0]       off;
  logic [3:0]       sum;
  assign rot = N_REQ'({req, req} >> ptr);
  // lowest set bit of the rotated mask is the distance from ptr to the winner
  always_comb begin
    off = '0;
    for (int k = N_REQ - 1; k >= 0; k--) if (rot[k]) off = 3'(k);
  end
  assign sum   = {1'b0, ptr} + {1'b0, off};
  assign idx   = 3'(sum >= 4'(N_REQ) ? sum - 4'(N_REQ) : sum);
  assign found = |req;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx among N_REQ byte streams with message lock
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ         = 4,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int BUSY_WAIT_MAX = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]     req_last,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [2:0]           grant_id,
  output logic                 grant_active,
  output logic                 lock_abort,
  output logic                 hs_error
);
  arb_state_t  state;
  logic [2:0]  rr_ptr, pick_idx, acc_id, nxt_ptr;
  logic        pick_found, sel_valid, sel_last, acc, lock;
  logic [7:0]  sel_data;
  logic [2:0]  bw_cnt;
  logic [15:0] to_cnt;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req  (req_valid),
    .ptr  (rr_ptr),
    .idx  (pick_idx),
    .found(pick_found)
  );

  // in HOLD only the current owner may send; otherwise the round-robin winner
  assign acc_id    = (state == HOLD) ? grant_id : pick_idx;
  assign sel_valid = 1'(req_valid >> acc_id);
  assign sel_last  = 1'(req_last >> acc_id);
  assign sel_data  = 8'(req_data >> {acc_id, 3'b000});
  assign acc       = (state == IDLE && !tx_busy && pick_found) || (state == HOLD && sel_valid);
  assign nxt_ptr   = next_idx(grant_id, N_REQ);

  // grant / handshake sequencer with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      req_ready    <= '0;
      tx_start     <= 1'b0;
      tx_data      <= '0;
      grant_id     <= '0;
      grant_active <= 1'b0;
      lock_abort   <= 1'b0;
      hs_error     <= 1'b0;
      lock         <= 1'b0;
      bw_cnt       <= '0;
      to_cnt       <= '0;
    end else begin
      req_ready  <= '0;
      tx_start   <= 1'b0;
      lock_abort <= 1'b0;
      if (acc) begin
        req_ready    <= N_REQ'(1) << acc_id;
        tx_data      <= sel_data;
        tx_start     <= 1'b1;
        grant_id     <= acc_id;
        grant_active <= 1'b1;
        lock         <= ~sel_last;
        bw_cnt       <= '0;
        state        <= WAIT_BUSY;
      end else if (state == WAIT_BUSY) begin
        if (tx_busy) state <= WAIT_DONE;
        else if (bw_cnt >= 3'(BUSY_WAIT_MAX - 1)) begin
          hs_error     <= 1'b1;
          lock         <= 1'b0;
          grant_active <= 1'b0;
          rr_ptr       <= nxt_ptr;
          state        <= IDLE;
        end else bw_cnt <= bw_cnt + 3'd1;
      end else if (state == WAIT_DONE && !tx_busy) begin
        if (lock) begin
          to_cnt <= '0;
          state  <= HOLD;
        end else begin
          grant_active <= 1'b0;
          rr_ptr       <= nxt_ptr;
          state        <= IDLE;
        end
      end else if (state == HOLD) begin
        if (to_cnt >= 16'(LOCK_TIMEOUT - 1)) begin
          lock_abort   <= 1'b1;
          lock         <= 1'b0;
          grant_active <= 1'b0;
          rr_ptr       <= nxt_ptr;
          state        <= IDLE;
        end else to_cnt <= to_cnt + 16'd1;
      end
    end
  end
endmodule
